// File: rtl/sd_cic_decimator.sv
// Third-order CIC (sinc3) decimator for a 1-bit sigma-delta stream with runtime ratio.
// Define SD_CIC_ROUND_EN to round half up instead of truncating when scaling down.

module sd_cic_decimator #(
    parameter int OUT_W         = 16,
    parameter int RATE_LOG2_MAX = 8,
    parameter int ACC_W         = 3 * RATE_LOG2_MAX + 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             VMOD,
    input  logic [1:0]       RATE,
    input  logic             MODE,
    output logic [OUT_W-1:0] Q,
    output logic             QV
);

    localparam int CW = RATE_LOG2_MAX;
    localparam int SW = ACC_W + OUT_W;
    localparam logic [7:0] OUT_W8 = 8'(OUT_W);
    localparam logic [7:0] K_MIN = 8'(RATE_LOG2_MAX - 3);
    localparam logic [SW-1:0] U_MAX = {{ACC_W{1'b0}}, {OUT_W{1'b1}}};

    logic [ACC_W-1:0] int1_q, int1_d;
    logic [ACC_W-1:0] int2_q, int2_d;
    logic [ACC_W-1:0] int3_q, int3_d;
    logic [ACC_W-1:0] dly1_q, dly1_d;
    logic [ACC_W-1:0] dly2_q, dly2_d;
    logic [ACC_W-1:0] dly3_q, dly3_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic [ACC_W-1:0] c1, c2, c3;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    r_max;
    logic [1:0]       settle_q, settle_d;
    logic [1:0]       rate_q, rate_d;
    logic             tick_q, tick_d;
    logic             emit1_q, emit1_d;
    logic             emit2_q, emit2_d;
    logic [OUT_W-1:0] q_q, q_d;
    logic             qv_q, qv_d;
    logic             restart;

    logic [7:0]       k;
    logic [7:0]       k3;
    logic [SW-1:0]    s_ext;
    logic [SW-1:0]    rnd;
    logic [SW-1:0]    wide;
    logic [OUT_W-1:0] u;
    logic [OUT_W-1:0] fmt;

    // A ratio change behaves like a reset that keeps the last output word.
    assign restart = (RATE != rate_q);

    always_comb begin
        k     = K_MIN + {6'd0, rate_q};
        k3    = k + k + k;
        r_max = {CW{1'b1}} >> (2'd3 - rate_q);
    end

    always_comb begin
        int1_d   = int1_q;
        int2_d   = int2_q;
        int3_d   = int3_q;
        cnt_d    = cnt_q;
        settle_d = settle_q;
        tick_d   = 1'b0;
        emit1_d  = 1'b0;
        if (EN) begin
            int1_d = int1_q + ACC_W'(VMOD);
            int2_d = int2_q + int1_d;
            int3_d = int3_q + int2_d;
            if (cnt_q == r_max) begin
                cnt_d   = '0;
                tick_d  = 1'b1;
                emit1_d = (settle_q == 2'd2);
                if (settle_q != 2'd2) begin
                    settle_d = settle_q + 2'd1;
                end
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        if (restart) begin
            int1_d   = '0;
            int2_d   = '0;
            int3_d   = '0;
            cnt_d    = '0;
            settle_d = '0;
            tick_d   = 1'b0;
            emit1_d  = 1'b0;
        end
    end

    always_comb begin
        c1      = int3_q - dly1_q;
        c2      = c1 - dly2_q;
        c3      = c2 - dly3_q;
        dly1_d  = dly1_q;
        dly2_d  = dly2_q;
        dly3_d  = dly3_q;
        sum_d   = sum_q;
        emit2_d = 1'b0;
        if (tick_q) begin
            dly1_d  = int3_q;
            dly2_d  = c1;
            dly3_d  = c2;
            sum_d   = c3;
            emit2_d = emit1_q;
        end
        if (restart) begin
            dly1_d  = '0;
            dly2_d  = '0;
            dly3_d  = '0;
            sum_d   = '0;
            emit2_d = 1'b0;
        end
    end

    // Only an all-ones window reaches 2^(3k), which lands one past full scale.
    always_comb begin
        s_ext = {{OUT_W{1'b0}}, sum_q};
        rnd   = '0;
        if (k3 >= OUT_W8) begin
`ifdef SD_CIC_ROUND_EN
            if (k3 > OUT_W8) begin
                rnd = SW'(1) << (k3 - OUT_W8 - 8'd1);
            end
`endif
            wide = (s_ext + rnd) >> (k3 - OUT_W8);
        end else begin
            wide = s_ext << (OUT_W8 - k3);
        end
        u   = (wide > U_MAX) ? {OUT_W{1'b1}} : wide[OUT_W-1:0];
        fmt = MODE ? {~u[OUT_W-1], u[OUT_W-2:0]} : u;
    end

    always_comb begin
        rate_d = RATE;
        q_d    = q_q;
        qv_d   = 1'b0;
        if (emit2_q && !restart) begin
            q_d  = fmt;
            qv_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            int1_q   <= '0;
            int2_q   <= '0;
            int3_q   <= '0;
            dly1_q   <= '0;
            dly2_q   <= '0;
            dly3_q   <= '0;
            sum_q    <= '0;
            cnt_q    <= '0;
            settle_q <= '0;
            rate_q   <= '0;
            tick_q   <= 1'b0;
            emit1_q  <= 1'b0;
            emit2_q  <= 1'b0;
            q_q      <= '0;
            qv_q     <= 1'b0;
        end else begin
            int1_q   <= int1_d;
            int2_q   <= int2_d;
            int3_q   <= int3_d;
            dly1_q   <= dly1_d;
            dly2_q   <= dly2_d;
            dly3_q   <= dly3_d;
            sum_q    <= sum_d;
            cnt_q    <= cnt_d;
            settle_q <= settle_d;
            rate_q   <= rate_d;
            tick_q   <= tick_d;
            emit1_q  <= emit1_d;
            emit2_q  <= emit2_d;
            q_q      <= q_d;
            qv_q     <= qv_d;
        end
    end

    assign Q  = q_q;
    assign QV = qv_q;

endmodule
